// File: rtl/rotate_frame_scheduler.sv
// Per-frame sequencer for the rotation engine: shadows user settings, applies
// them at frame boundaries, picks the read bank, launches one rotation pass per
// written frame, counts output pixels and flags engine stalls.
module rotate_frame_scheduler #(
  parameter int IMAGE_W     = 1280,
  parameter int IMAGE_H     = 720,
  parameter int TO_W        = 24,
  parameter int TIMEOUT_CYC = 4000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [1:0]  wr_bank_done,
  input  logic [7:0]  cfg_angle,
  input  logic [9:0]  cfg_amplitude,
  input  logic [11:0] cfg_offset_x,
  input  logic [11:0] cfg_offset_y,
  input  logic        cfg_update,
  input  logic        err_clr,
  input  logic        pix_valid,
  output logic        rot_en,
  output logic [7:0]  rot_angle,
  output logic [9:0]  rot_amplitude,
  output logic [11:0] rot_offset_x,
  output logic [11:0] rot_offset_y,
  output logic [1:0]  rd_bank,
  output logic        busy,
  output logic        frame_done,
  output logic        err_timeout,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt
);

  localparam logic [20:0]     LAST_PIX  = 21'(IMAGE_W * IMAGE_H - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [9:0]      AMP_UNITY = 10'd128;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_LOAD  = 4'b0010,
    S_START = 4'b0100,
    S_RUN   = 4'b1000
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic            r_pending;
  logic [1:0]      r_pend_bank;
  logic [7:0]      r_sh_angle;
  logic [9:0]      r_sh_amplitude;
  logic [11:0]     r_sh_offset_x;
  logic [11:0]     r_sh_offset_y;
  logic [7:0]      r_angle;
  logic [9:0]      r_amplitude;
  logic [11:0]     r_offset_x;
  logic [11:0]     r_offset_y;
  logic [1:0]      r_rd_bank;
  logic            r_rot_en;
  logic            r_frame_done;
  logic            r_err_timeout;
  logic [15:0]     r_frame_cnt;
  logic [7:0]      r_drop_cnt;
  logic [20:0]     r_pix_cnt;
  logic [TO_W-1:0] r_to_cnt;

  logic w_last_pix;
  logic w_timeout;

  // Last pixel of the frame, and a stall that has run out its allowance.
  assign w_last_pix = (r_state == S_RUN) && pix_valid && (r_pix_cnt == LAST_PIX);
  assign w_timeout  = (r_state == S_RUN) && !pix_valid && (r_to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; a frame_start seen in IDLE launches LOAD without waiting a cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (r_pending || frame_start) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_START;
      S_START: w_state_next = S_RUN;
      S_RUN:   if (w_last_pix || w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pending frame slot: latest frame wins; an overwrite outside LOAD counts as a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= 1'b0;
      r_pend_bank <= 2'd0;
      r_drop_cnt  <= 8'd0;
    end else if (frame_start) begin
      r_pending   <= 1'b1;
      r_pend_bank <= wr_bank_done;
      if (r_pending && (r_state != S_LOAD) && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (r_state == S_LOAD) begin
      r_pending <= 1'b0;
    end
  end

  // Shadow config captures user writes at any time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_angle     <= 8'd0;
      r_sh_amplitude <= AMP_UNITY;
      r_sh_offset_x  <= 12'd0;
      r_sh_offset_y  <= 12'd0;
    end else if (cfg_update) begin
      r_sh_angle     <= cfg_angle;
      r_sh_amplitude <= cfg_amplitude;
      r_sh_offset_x  <= cfg_offset_x;
      r_sh_offset_y  <= cfg_offset_y;
    end
  end

  // Active config and read bank move only in LOAD so the engine sees stable values all frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_angle     <= 8'd0;
      r_amplitude <= AMP_UNITY;
      r_offset_x  <= 12'd0;
      r_offset_y  <= 12'd0;
      r_rd_bank   <= 2'd0;
    end else if (r_state == S_LOAD) begin
      r_angle     <= r_sh_angle;
      r_amplitude <= r_sh_amplitude;
      r_offset_x  <= r_sh_offset_x;
      r_offset_y  <= r_sh_offset_y;
      r_rd_bank   <= r_pend_bank;
    end
  end

  // Engine strobe, pixel/stall counting, completion and sticky stall flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rot_en      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_frame_cnt   <= 16'd0;
      r_pix_cnt     <= 21'd0;
      r_to_cnt      <= '0;
    end else begin
      r_rot_en     <= (r_state == S_START);
      r_frame_done <= w_last_pix;
      if (w_last_pix) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_state == S_START) begin
        r_pix_cnt <= 21'd0;
        r_to_cnt  <= '0;
      end else if (r_state == S_RUN) begin
        if (pix_valid) begin
          r_pix_cnt <= r_pix_cnt + 21'd1;
          r_to_cnt  <= '0;
        end else if (!w_timeout) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
      if (w_timeout)    r_err_timeout <= 1'b1;
      else if (err_clr) r_err_timeout <= 1'b0;
    end
  end

  assign rot_en        = r_rot_en;
  assign rot_angle     = r_angle;
  assign rot_amplitude = r_amplitude;
  assign rot_offset_x  = r_offset_x;
  assign rot_offset_y  = r_offset_y;
  assign rd_bank       = r_rd_bank;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = r_frame_done;
  assign err_timeout   = r_err_timeout;
  assign frame_cnt     = r_frame_cnt;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_rotate_frame_scheduler.sv
// Self-checking bench for rotate_frame_scheduler on a small 8x4 frame with a
// 100-cycle stall limit: table-driven frames plus hand-written corner sequences.
module tb_rotate_frame_scheduler;

  localparam int IW   = 8;
  localparam int IH   = 4;
  localparam int NPIX = IW * IH;
  localparam int TOC  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [1:0]  wr_bank_done = 2'd0;
  logic [7:0]  cfg_angle = 8'd0;
  logic [9:0]  cfg_amplitude = 10'd0;
  logic [11:0] cfg_offset_x = 12'd0;
  logic [11:0] cfg_offset_y = 12'd0;
  logic        cfg_update = 1'b0;
  logic        err_clr = 1'b0;
  logic        pix_valid = 1'b0;
  logic        rot_en;
  logic [7:0]  rot_angle;
  logic [9:0]  rot_amplitude;
  logic [11:0] rot_offset_x;
  logic [11:0] rot_offset_y;
  logic [1:0]  rd_bank;
  logic        busy;
  logic        frame_done;
  logic        err_timeout;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  rotate_frame_scheduler #(
    .IMAGE_W(IW), .IMAGE_H(IH), .TO_W(8), .TIMEOUT_CYC(TOC)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .wr_bank_done(wr_bank_done),
    .cfg_angle(cfg_angle), .cfg_amplitude(cfg_amplitude),
    .cfg_offset_x(cfg_offset_x), .cfg_offset_y(cfg_offset_y),
    .cfg_update(cfg_update), .err_clr(err_clr), .pix_valid(pix_valid),
    .rot_en(rot_en), .rot_angle(rot_angle), .rot_amplitude(rot_amplitude),
    .rot_offset_x(rot_offset_x), .rot_offset_y(rot_offset_y), .rd_bank(rd_bank),
    .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bank;
    logic [7:0]  angle;
    logic [9:0]  amp;
    logic [11:0] ox;
    logic [11:0] oy;
  } exp_frame_t;

  typedef struct {
    logic [1:0]  bank;
    logic [7:0]  angle;
    logic [9:0]  amp;
    logic [11:0] ox;
    logic [11:0] oy;
    int          gap;
    logic [15:0] exp_fcnt;
  } frame_vec_t;

  exp_frame_t exp_q[$];
  exp_frame_t sh;
  exp_frame_t e_pop;
  frame_vec_t vecs[4];

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_rot    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the edge and the scoreboard is
  // popped whenever the engine start strobe is seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) begin
      if (frame_done) n_done++;
      if (rot_en) begin
        n_rot++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_rot_en_unexpected: got 1, expected 0");
        end else begin
          e_pop = exp_q.pop_front();
          check("sb_rd_bank", 32'(rd_bank), 32'(e_pop.bank));
          check("sb_angle", 32'(rot_angle), 32'(e_pop.angle));
          check("sb_amplitude", 32'(rot_amplitude), 32'(e_pop.amp));
          check("sb_offset_x", 32'(rot_offset_x), 32'(e_pop.ox));
          check("sb_offset_y", 32'(rot_offset_y), 32'(e_pop.oy));
          $display("rot_en: bank=%0d angle=%0d amp=%0d ox=%0d oy=%0d",
                   rd_bank, rot_angle, rot_amplitude, rot_offset_x, rot_offset_y);
        end
      end
    end
  endtask

  task automatic push_exp(input logic [1:0] b);
    exp_frame_t t;
    t = sh;
    t.bank = b;
    exp_q.push_back(t);
  endtask

  task automatic do_cfg(input logic [7:0] a, input logic [9:0] m,
                        input logic [11:0] x, input logic [11:0] y);
    cfg_angle = a; cfg_amplitude = m; cfg_offset_x = x; cfg_offset_y = y;
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    sh.angle = a; sh.amp = m; sh.ox = x; sh.oy = y;
  endtask

  task automatic pulse_fs(input logic [1:0] b);
    frame_start = 1'b1;
    wr_bank_done = b;
    tick();
    frame_start = 1'b0;
  endtask

  // Cycles until rot_en, counting from the given cycle index; 20 means never.
  task automatic wait_rot(input int start, output int lat);
    lat = start;
    while (!rot_en && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Feeds n pixels separated by gap idle cycles; returns with the cycle after
  // the last pixel current and reports any frame_done seen before that.
  task automatic feed(input int n, input int gap, output int early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      if (i < n - 1) begin
        if (frame_done) early++;
        for (int g = 0; g < gap; g++) begin
          tick();
          if (frame_done) early++;
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rot_en"}, 32'(rot_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 0);
    check({tag, "_rd_bank"}, 32'(rd_bank), 0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
    check({tag, "_angle"}, 32'(rot_angle), 0);
    check({tag, "_amplitude"}, 32'(rot_amplitude), 128);
    check({tag, "_offset_x"}, 32'(rot_offset_x), 0);
    check({tag, "_offset_y"}, 32'(rot_offset_y), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int early;
    int cnt;
    int snap;

    vecs[0] = '{2'd1, 8'd32,  10'd128,  12'd10,  12'hFFB, 0, 16'd1};
    vecs[1] = '{2'd2, 8'd200, 10'd1023, 12'h7FF, 12'h800, 1, 16'd2};
    vecs[2] = '{2'd3, 8'd255, 10'd0,    12'h800, 12'h001, 3, 16'd3};
    vecs[3] = '{2'd0, 8'd7,   10'd512,  12'hABC, 12'h123, 2, 16'd4};
    sh = '{2'd0, 8'd0, 10'd128, 12'd0, 12'd0};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals("reset");

    // Table-driven single frames.
    for (int v = 0; v < 4; v++) begin
      do_cfg(vecs[v].angle, vecs[v].amp, vecs[v].ox, vecs[v].oy);
      push_exp(vecs[v].bank);
      pulse_fs(vecs[v].bank);
      wait_rot(1, lat);
      check("vec_latency", 32'(lat), 3);
      check("vec_busy_run", 32'(busy), 1);
      feed(NPIX, vecs[v].gap, early);
      check("vec_early_done", 32'(early), 0);
      check("vec_frame_done", 32'(frame_done), 1);
      check("vec_frame_cnt", 32'(frame_cnt), 32'(vecs[v].exp_fcnt));
      check("vec_rd_bank", 32'(rd_bank), 32'(vecs[v].bank));
      check("vec_angle", 32'(rot_angle), 32'(vecs[v].angle));
      tick();
      check("vec_done_pulse", 32'(frame_done), 0);
      check("vec_idle", 32'(busy), 0);
      $display("frame vec %0d: bank=%0d frame_cnt=%0d", v, rd_bank, frame_cnt);
    end

    // Shadow isolation: a mid-frame cfg_update waits for the next LOAD.
    do_cfg(8'd32, 10'd128, 12'd10, 12'hFFB);
    push_exp(2'd1);
    pulse_fs(2'd1);
    wait_rot(1, lat);
    feed(10, 0, early);
    do_cfg(8'd64, 10'd128, 12'd10, 12'hFFB);
    tick();
    check("shadow_hold_angle", 32'(rot_angle), 32);
    feed(NPIX - 10, 0, early);
    check("shadow_early_done", 32'(early), 0);
    check("shadow_frame_cnt", 32'(frame_cnt), 5);
    push_exp(2'd2);
    pulse_fs(2'd2);
    wait_rot(1, lat);
    check("shadow_new_angle", 32'(rot_angle), 64);
    $display("shadow: angle now %0d", rot_angle);

    // Overwrite of a pending frame, then LOAD coinciding with frame_start and cfg_update.
    feed(5, 0, early);
    push_exp(2'd2);
    pulse_fs(2'd2);
    check("ovw_first_no_drop", 32'(drop_cnt), 0);
    void'(exp_q.pop_back());
    push_exp(2'd0);
    pulse_fs(2'd0);
    check("ovw_drop_cnt", 32'(drop_cnt), 1);
    feed(NPIX - 5, 0, early);
    check("ovw_frame_done", 32'(frame_done), 1);
    check("ovw_frame_cnt", 32'(frame_cnt), 6);
    tick();
    frame_start = 1'b1;
    wr_bank_done = 2'd3;
    cfg_angle = 8'd99;
    cfg_update = 1'b1;
    sh.angle = 8'd99;
    push_exp(2'd3);
    tick();
    frame_start = 1'b0;
    cfg_update = 1'b0;
    tick();
    check("b2b_rot_en", 32'(rot_en), 1);
    check("b2b_rd_bank", 32'(rd_bank), 0);
    check("load_cfg_old_angle", 32'(rot_angle), 64);
    check("load_fs_drop_cnt", 32'(drop_cnt), 1);
    feed(NPIX, 0, early);
    check("b2b_frame_cnt", 32'(frame_cnt), 7);
    wait_rot(0, lat);
    check("pend_kept_latency", 32'(lat), 3);
    check("pend_kept_bank", 32'(rd_bank), 3);
    check("pend_kept_angle", 32'(rot_angle), 99);
    feed(NPIX, 1, early);
    check("pend_kept_frame_cnt", 32'(frame_cnt), 8);
    $display("overwrite: drop_cnt=%0d frame_cnt=%0d", drop_cnt, frame_cnt);

    // Stall: 10 pixels then silence.
    tick();
    push_exp(2'd1);
    pulse_fs(2'd1);
    wait_rot(1, lat);
    snap = n_done;
    feed(10, 0, early);
    cnt = 0;
    while (!err_timeout && cnt < 300) begin
      tick();
      cnt++;
    end
    check("to_delay", 32'(cnt), 100);
    check("to_idle", 32'(busy), 0);
    check("to_no_done", 32'(n_done - snap), 0);
    check("to_frame_cnt", 32'(frame_cnt), 8);
    repeat (3) tick();
    check("to_sticky", 32'(err_timeout), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_clr", 32'(err_timeout), 0);
    $display("timeout: flagged after %0d cycles", cnt);

    // Stall while err_clr is held: set must win on the timeout edge.
    push_exp(2'd0);
    pulse_fs(2'd0);
    wait_rot(1, lat);
    err_clr = 1'b1;
    cnt = 0;
    while (busy && cnt < 300) begin
      tick();
      cnt++;
    end
    check("to_set_wins", 32'(err_timeout), 1);
    tick();
    check("to_clr_after", 32'(err_timeout), 0);
    err_clr = 1'b0;

    // Reset mid-frame with a pending frame and a fresh shadow write.
    push_exp(2'd2);
    pulse_fs(2'd2);
    wait_rot(1, lat);
    feed(20, 0, early);
    pulse_fs(2'd1);
    do_cfg(8'd5, 10'd6, 12'd7, 12'd8);
    snap = n_done;
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    exp_q.delete();
    sh = '{2'd0, 8'd0, 10'd128, 12'd0, 12'd0};
    cnt = n_rot;
    repeat (6) tick();
    check("midrst_no_start", 32'(n_rot - cnt), 0);
    check("midrst_idle", 32'(busy), 0);
    check("midrst_no_done", 32'(n_done - snap), 0);
    push_exp(2'd3);
    pulse_fs(2'd3);
    wait_rot(1, lat);
    check("post_rst_latency", 32'(lat), 3);
    feed(NPIX, 0, early);
    check("post_rst_early", 32'(early), 0);
    check("post_rst_done", 32'(frame_done), 1);
    check("post_rst_frame_cnt", 32'(frame_cnt), 1);
    $display("reset: recovered, frame_cnt=%0d", frame_cnt);

    // Stray pixels in IDLE must not count toward the next frame.
    tick();
    snap = n_done;
    pix_valid = 1'b1;
    repeat (5) tick();
    pix_valid = 1'b0;
    check("stray_no_done", 32'(n_done - snap), 0);
    check("stray_frame_cnt", 32'(frame_cnt), 1);
    check("stray_idle", 32'(busy), 0);
    push_exp(2'd1);
    pulse_fs(2'd1);
    wait_rot(1, lat);
    feed(NPIX, 0, early);
    check("stray_full_frame_early", 32'(early), 0);
    check("stray_full_frame_done", 32'(frame_done), 1);
    check("stray_full_frame_cnt", 32'(frame_cnt), 2);
    tick();
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("stray: frame_cnt=%0d", frame_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
